// File: rtl/edge_pp_pkg.sv
// Shared types and constants for the Sobel edge post-processing stage.
package edge_pp_pkg;

  localparam int PIX_DW = 12;
  localparam logic [PIX_DW-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {
    MODE_RAW  = 2'd0,
    MODE_BIN  = 2'd1,
    MODE_GAIN = 2'd2,
    MODE_OVL  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/edge_postproc_if.sv
// Pixel/stat bundle between the Sobel stage, this post-processor and the
// SDRAM write / display logic. The slave side is the post-processor.
interface edge_postproc_if #(
  parameter int DW    = 12,
  parameter int CNT_W = 19
);
  logic [DW-1:0]    iDATA;
  logic             iDVAL;
  logic             iSOF;
  logic [DW-1:0]    iTHRESH;
  logic [1:0]       iMODE;
  logic [DW-1:0]    oRed;
  logic [DW-1:0]    oGreen;
  logic [DW-1:0]    oBlue;
  logic             oDVAL;
  logic [CNT_W-1:0] oEDGE_COUNT;
  logic             oSTAT_VALID;
  logic             oFRAME_ERR;

  modport master (
    output iDATA, iDVAL, iSOF, iTHRESH, iMODE,
    input  oRed, oGreen, oBlue, oDVAL, oEDGE_COUNT, oSTAT_VALID, oFRAME_ERR
  );

  modport slave (
    input  iDATA, iDVAL, iSOF, iTHRESH, iMODE,
    output oRed, oGreen, oBlue, oDVAL, oEDGE_COUNT, oSTAT_VALID, oFRAME_ERR
  );
endinterface

// File: rtl/edge_pp_pos_counter.sv
// Raster position tracker: x/y of the pixel currently presented, plus
// interior (outside the Sobel border) and last-pixel-of-frame flags.
module edge_pp_pos_counter #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int BORDER = 1
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic clr,
  input  logic adv,
  output logic interior,
  output logic last_pix
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_LO   = XW'(BORDER);
  localparam logic [XW-1:0] X_HI   = XW'(IMG_W - BORDER);
  localparam logic [YW-1:0] Y_LO   = YW'(BORDER);
  localparam logic [YW-1:0] Y_HI   = YW'(IMG_H - BORDER);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // Advance one position per accepted pixel, wrapping at line and frame end.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign interior = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  assign last_pix = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/edge_postproc.sv
// Edge post-processor: thresholds Sobel magnitude, masks the border,
// maps to RGB per a frame-latched display mode and counts edge pixels.
module edge_postproc
  import edge_pp_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DW     = PIX_DW,
  parameter int BORDER = 1,
  parameter int CNT_W  = 19
) (
  input logic iCLK,
  input logic iRST,
  edge_postproc_if.slave bus
);

  localparam int STAGES = 2;
  localparam logic [DW-1:0]    ALL_ONES = {DW{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef struct packed {
    logic [DW-1:0] data;
    logic          is_edge;
    logic          interior;
    mode_t         mode;
  } s1_t;

  state_t           state;
  logic [DW-1:0]    thresh_q;
  mode_t            mode_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] edge_count_q;
  logic             stat_valid_q;
  logic             frame_err_q;

  logic [STAGES:1]  vld_pipe;
  s1_t              s1_q;
  logic [DW-1:0]    red_q, green_q, blue_q;
  logic [DW-1:0]    red_d, green_d, blue_d;
  logic [DW+1:0]    gain;

  logic             interior;
  logic             last_pix;
  logic             accept;
  logic             is_edge;
  logic [CNT_W-1:0] count_next;

  // A start-of-frame always wins over a same-cycle pixel.
  assign accept     = (state == ACTIVE) && bus.iDVAL && !bus.iSOF;
  assign is_edge    = interior && (bus.iDATA >= thresh_q);
  assign count_next = (is_edge && (count_q != CNT_MAX)) ? count_q + 1'b1 : count_q;

  edge_pp_pos_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .BORDER (BORDER)
  ) u_pos (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .clr      (bus.iSOF),
    .adv      (accept),
    .interior (interior),
    .last_pix (last_pix)
  );

  // Frame FSM: latches settings at SOF, accumulates count, publishes stats.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state        <= WAIT_SOF;
      thresh_q     <= '0;
      mode_q       <= MODE_RAW;
      count_q      <= '0;
      edge_count_q <= '0;
      stat_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      stat_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (bus.iSOF) begin
        state    <= ACTIVE;
        thresh_q <= bus.iTHRESH;
        mode_q   <= mode_t'(bus.iMODE);
        count_q  <= '0;
        if (state == ACTIVE) frame_err_q <= 1'b1;
      end else begin
        case (state)
          WAIT_SOF: state <= WAIT_SOF;
          ACTIVE: begin
            if (accept) begin
              count_q <= count_next;
              if (last_pix) begin
                state        <= DONE;
                edge_count_q <= count_next;
                stat_valid_q <= 1'b1;
              end
            end
          end
          DONE:    state <= WAIT_SOF;
          default: state <= WAIT_SOF;
        endcase
      end
    end
  end

  // Display mapping from the stage-1 snapshot; border pixels go black.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    gain    = {2'b00, s1_q.data} << 2;
    if (s1_q.interior) begin
      case (s1_q.mode)
        MODE_RAW: begin
          red_d   = s1_q.data;
          green_d = s1_q.data;
          blue_d  = s1_q.data;
        end
        MODE_BIN: begin
          red_d   = s1_q.is_edge ? ALL_ONES : '0;
          green_d = s1_q.is_edge ? ALL_ONES : '0;
          blue_d  = s1_q.is_edge ? ALL_ONES : '0;
        end
        MODE_GAIN: begin
          red_d   = (gain > {2'b00, ALL_ONES}) ? ALL_ONES : gain[DW-1:0];
          green_d = red_d;
          blue_d  = red_d;
        end
        MODE_OVL: begin
          if (s1_q.is_edge) begin
            red_d = ALL_ONES;
          end else begin
            red_d   = s1_q.data >> 1;
            green_d = s1_q.data >> 1;
            blue_d  = s1_q.data >> 1;
          end
        end
        default: red_d = '0;
      endcase
    end
  end

  // Two-stage pixel pipeline; outputs hold between valid pixels.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) begin
        s1_q <= '{data: bus.iDATA, is_edge: is_edge, interior: interior, mode: mode_q};
      end
      if (vld_pipe[1]) begin
        red_q   <= red_d;
        green_q <= green_d;
        blue_q  <= blue_d;
      end
    end
  end

  assign bus.oRed        = red_q;
  assign bus.oGreen      = green_q;
  assign bus.oBlue       = blue_q;
  assign bus.oDVAL       = vld_pipe[STAGES];
  assign bus.oEDGE_COUNT = edge_count_q;
  assign bus.oSTAT_VALID = stat_valid_q;
  assign bus.oFRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_edge_postproc.sv
// Directed bench for edge_postproc on an 8x4 frame with a 1-pixel border.
module tb_edge_postproc;
  import edge_pp_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int B  = 1;
  localparam int DW = 12;
  localparam int CW = 19;

  logic iCLK = 1'b0;
  logic iRST;

  edge_postproc_if #(.DW(DW), .CNT_W(CW)) bus ();

  edge_postproc #(
    .IMG_W(W), .IMG_H(H), .DW(DW), .BORDER(B), .CNT_W(CW)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  int n_chk  = 0;
  int n_fail = 0;
  int n_stat = 0;
  int n_err  = 0;
  int px     = 0;
  int py     = 0;

  // expectation for the pixel driven one step earlier (appears 2 edges later)
  logic        p_v = 1'b0;
  logic [11:0] p_r = '0, p_g = '0, p_b = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic sof, input logic dv, input logic [11:0] d,
                      input logic ev, input logic [11:0] er, input logic [11:0] eg,
                      input logic [11:0] eb);
    bus.iSOF  = sof;
    bus.iDVAL = dv;
    bus.iDATA = d;
    @(negedge iCLK);
    chk("odval", {31'd0, bus.oDVAL}, {31'd0, p_v});
    if (p_v) begin
      chk("red",   {20'd0, bus.oRed},   {20'd0, p_r});
      chk("green", {20'd0, bus.oGreen}, {20'd0, p_g});
      chk("blue",  {20'd0, bus.oBlue},  {20'd0, p_b});
    end
    if (bus.oSTAT_VALID) n_stat++;
    if (bus.oFRAME_ERR)  n_err++;
    p_v = ev;
    p_r = er;
    p_g = eg;
    p_b = eb;
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 12'hABC, 1'b0, 12'h0, 12'h0, 12'h0);
  endtask

  task automatic sof(input logic [1:0] mode, input logic [11:0] thr);
    bus.iMODE   = mode;
    bus.iTHRESH = thr;
    step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 12'h0, 12'h0);
    px = 0;
    py = 0;
  endtask

  // one accepted pixel; ir/ig/ib are the interior results, border gives 0
  task automatic pix(input logic [11:0] d, input logic [11:0] ir,
                     input logic [11:0] ig, input logic [11:0] ib);
    logic in_f;
    in_f = (px >= B) && (px < W - B) && (py >= B) && (py < H - B);
    step(1'b0, 1'b1, d, 1'b1, in_f ? ir : 12'h0, in_f ? ig : 12'h0, in_f ? ib : 12'h0);
    px++;
    if (px == W) begin
      px = 0;
      py++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    iRST        = 1'b0;
    bus.iDATA   = '0;
    bus.iDVAL   = 1'b0;
    bus.iSOF    = 1'b0;
    bus.iTHRESH = '0;
    bus.iMODE   = '0;
    repeat (3) @(negedge iCLK);
    chk("rst_dval",  {31'd0, bus.oDVAL}, 32'd0);
    chk("rst_red",   {20'd0, bus.oRed}, 32'd0);
    chk("rst_count", {13'd0, bus.oEDGE_COUNT}, 32'd0);
    chk("rst_stat",  {31'd0, bus.oSTAT_VALID}, 32'd0);
    chk("rst_err",   {31'd0, bus.oFRAME_ERR}, 32'd0);
    iRST = 1'b1;

    // 1: pixels before any SOF are ignored
    bus.iMODE = 2'd0;
    repeat (10) step(1'b0, 1'b1, 12'h123, 1'b0, 12'h0, 12'h0, 12'h0);
    gap();
    chk("nosof_red",   {20'd0, bus.oRed},   32'd0);
    chk("nosof_green", {20'd0, bus.oGreen}, 32'd0);
    chk("nosof_blue",  {20'd0, bus.oBlue},  32'd0);
    chk("nosof_count", {13'd0, bus.oEDGE_COUNT}, 32'd0);
    chk("nosof_stat",  n_stat, 0);

    // 2: binary mode, every interior pixel above threshold
    sof(2'd1, 12'h100);
    for (int i = 0; i < 32; i++) pix(12'h200, PIX_MAX, PIX_MAX, PIX_MAX);
    gap();
    chk("bin_count", {13'd0, bus.oEDGE_COUNT}, 32'd12);
    chk("bin_stat",  n_stat, 1);

    // 3: gain x4 with saturation; threshold equal to data counts as edge
    n_stat = 0;
    sof(2'd2, 12'h500);
    for (int i = 0; i < 32; i++) begin
      if (py < 2) pix(12'h3FF, 12'hFFC, 12'hFFC, 12'hFFC);
      else        pix(12'h500, PIX_MAX, PIX_MAX, PIX_MAX);
    end
    // 4: SOF lands in the DONE cycle; overlay mode
    sof(2'd3, 12'h800);
    chk("gain_count", {13'd0, bus.oEDGE_COUNT}, 32'd6);
    chk("gain_stat",  n_stat, 1);
    chk("done_sof_err", n_err, 0);
    n_stat = 0;
    for (int i = 0; i < 32; i++) begin
      if (px < 5) pix(12'h900, PIX_MAX, 12'h000, 12'h000);
      else        pix(12'h400, 12'h200, 12'h200, 12'h200);
    end
    gap();
    chk("ovl_count", {13'd0, bus.oEDGE_COUNT}, 32'd8);
    chk("ovl_stat",  n_stat, 1);

    // 5: abort after 20 pixels, new frame with new settings
    n_stat = 0;
    n_err  = 0;
    sof(2'd0, 12'h100);
    for (int i = 0; i < 20; i++) pix(12'h200, 12'h200, 12'h200, 12'h200);
    sof(2'd1, 12'h300);
    chk("abort_err",  n_err, 1);
    chk("abort_hold", {13'd0, bus.oEDGE_COUNT}, 32'd8);
    for (int i = 0; i < 16; i++) pix(12'h300, PIX_MAX, PIX_MAX, PIX_MAX);
    chk("abort_mid_hold", {13'd0, bus.oEDGE_COUNT}, 32'd8);
    for (int i = 0; i < 16; i++) pix(12'h300, PIX_MAX, PIX_MAX, PIX_MAX);
    gap();
    chk("restart_count", {13'd0, bus.oEDGE_COUNT}, 32'd12);
    chk("restart_stat",  n_stat, 1);
    chk("restart_err",   n_err, 1);

    // 6: settings change mid-frame and iDVAL gaps
    n_stat = 0;
    sof(2'd3, 12'h800);
    for (int i = 0; i < 32; i++) begin
      if (i == 10) begin
        bus.iMODE   = 2'd0;
        bus.iTHRESH = 12'h000;
      end
      if (i < 16) pix(12'h900, PIX_MAX, 12'h000, 12'h000);
      else        pix(12'h100, 12'h080, 12'h080, 12'h080);
      if (i % 3 == 0) gap();
    end
    gap();
    chk("midchg_count", {13'd0, bus.oEDGE_COUNT}, 32'd6);
    chk("midchg_stat",  n_stat, 1);
    sof(2'd0, 12'h000);
    for (int i = 0; i < 32; i++) pix(12'h123, 12'h123, 12'h123, 12'h123);
    gap();
    chk("newset_count", {13'd0, bus.oEDGE_COUNT}, 32'd12);
    chk("newset_stat",  n_stat, 2);

    // reset mid-frame flushes the pipe and clears the published count
    sof(2'd1, 12'h100);
    for (int i = 0; i < 5; i++) pix(12'h200, PIX_MAX, PIX_MAX, PIX_MAX);
    iRST      = 1'b0;
    bus.iDVAL = 1'b0;
    p_v       = 1'b0;
    #1;
    chk("midrst_dval",  {31'd0, bus.oDVAL}, 32'd0);
    chk("midrst_count", {13'd0, bus.oEDGE_COUNT}, 32'd0);
    chk("midrst_red",   {20'd0, bus.oRed}, 32'd0);
    @(negedge iCLK);
    iRST = 1'b1;
    step(1'b0, 1'b1, 12'h200, 1'b0, 12'h0, 12'h0, 12'h0);
    gap();
    gap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
